// File: rtl/phase_sequencer_pkg.sv
// Shared state codes and helpers for the iteration sequencer and its phase modules.
package phase_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_GET_PARAM  = 3'd1,
    S_GET_DATA   = 3'd2,
    S_EX         = 3'd3,
    S_WRITE_BACK = 3'd4,
    S_DONE       = 3'd5,
    S_ERR        = 3'd6
  } state_e;

  localparam int NUM_PHASES = 3;

  // A fixed-latency phase always dwells at least one cycle.
  function automatic int eff_lat(input int lat);
    return (lat < 1) ? 1 : lat;
  endfunction

endpackage

// File: rtl/phase_sequencer_timer.sv
// Loadable down-counter with a terminal (zero) flag; saturates at zero.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt_q <= '0;
    else if (load_i)                   cnt_q <= load_val_i;
    else if (en_i && (cnt_q != '0))    cnt_q <= cnt_q - W'(1);
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Iteration sequencer: GET_PARAM -> GET_DATA -> EX -> WRITE_BACK per iteration,
// with per-phase fixed/handshake dwell, iteration limit, abort, timeout and restart.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int         ITER_W   = 16,
  parameter int         LAT_W    = 4,
  parameter int         DATA_LAT = 1,
  parameter int         EX_LAT   = 1,
  parameter int         WB_LAT   = 1,
  parameter logic [2:0] HS_MODE  = 3'b000,
  parameter int         TO_W     = 8,
  parameter int         TIMEOUT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              is_start,
  input  logic              abort,
  input  logic [ITER_W-1:0] iter_limit,
  input  logic              is_find,
  input  logic              is_finish,
  input  logic [2:0]        phase_done,
  output logic [2:0]        state,
  output logic [2:0]        phase_start,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  // Timer reload values: a phase dwells (load value + 1) cycles.
  localparam logic [LAT_W-1:0] DATA_LD = LAT_W'(eff_lat(DATA_LAT) - 1);
  localparam logic [LAT_W-1:0] EX_LD   = LAT_W'(eff_lat(EX_LAT) - 1);
  localparam logic [LAT_W-1:0] WB_LD   = LAT_W'(eff_lat(WB_LAT) - 1);
  localparam logic [TO_W-1:0]  TO_LD   = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   iter_cnt_q, limit_q, iter_inc;
  logic [2:0]          phase_start_q, phase_start_d;
  logic                state_chg, run_busy;
  logic                ph_hs, ph_done, ph_exit, waiting, exit_cond, to_hit;
  logic                start_run, wb_adv;
  logic                lat_zero, to_zero;
  logic [LAT_W-1:0]    lat_ld;

  assign iter_inc  = iter_cnt_q + ITER_W'(1);
  assign state_chg = (state_d != state_q);
  assign run_busy  = (state_q == S_GET_PARAM) || (state_q == S_GET_DATA) ||
                     (state_q == S_EX) || (state_q == S_WRITE_BACK);

  // Fixed-latency dwell counter, reloaded on every state change.
  phase_timer #(.W(LAT_W)) u_lat_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_chg),
    .load_val_i (lat_ld),
    .en_i       (1'b1),
    .zero_o     (lat_zero)
  );

  // Wait/timeout counter, runs only while waiting on an external condition.
  phase_timer #(.W(TO_W)) u_to_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_chg),
    .load_val_i (TO_LD),
    .en_i       (waiting),
    .zero_o     (to_zero)
  );

  // Reload value for the dwell counter, chosen by the phase being entered.
  always_comb begin
    lat_ld = '0;
    case (state_d)
      S_GET_DATA:   lat_ld = DATA_LD;
      S_EX:         lat_ld = EX_LD;
      S_WRITE_BACK: lat_ld = WB_LD;
      default:      lat_ld = '0;
    endcase
  end

  // Current phase's completion mode and exit/timeout conditions.
  always_comb begin
    ph_hs   = 1'b0;
    ph_done = 1'b0;
    case (state_q)
      S_GET_DATA:   begin ph_hs = HS_MODE[0]; ph_done = phase_done[0]; end
      S_EX:         begin ph_hs = HS_MODE[1]; ph_done = phase_done[1]; end
      S_WRITE_BACK: begin ph_hs = HS_MODE[2]; ph_done = phase_done[2]; end
      default:      begin ph_hs = 1'b0;       ph_done = 1'b0;          end
    endcase
    ph_exit   = ph_hs ? ph_done : lat_zero;
    waiting   = (state_q == S_GET_PARAM) || ph_hs;
    exit_cond = (state_q == S_GET_PARAM) ? is_find : ph_exit;
    to_hit    = (TIMEOUT != 0) && waiting && to_zero && !exit_cond;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: abort > is_finish > timeout > normal sequencing.
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    wb_adv    = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else if (is_finish && run_busy) begin
      state_d = S_DONE;
    end else if (to_hit) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (is_start) begin
          state_d   = S_GET_PARAM;
          start_run = 1'b1;
        end
        S_GET_PARAM:  if (is_find) state_d = S_GET_DATA;
        S_GET_DATA:   if (ph_exit) state_d = S_EX;
        S_EX:         if (ph_exit) state_d = S_WRITE_BACK;
        S_WRITE_BACK: if (ph_exit) begin
          wb_adv  = 1'b1;
          state_d = ((limit_q != '0) && (iter_inc == limit_q)) ? S_DONE : S_GET_PARAM;
        end
        S_ERR:        state_d = S_ERR;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // One-cycle entry pulse for each data phase.
  always_comb begin
    phase_start_d    = '0;
    phase_start_d[0] = state_chg && (state_d == S_GET_DATA);
    phase_start_d[1] = state_chg && (state_d == S_EX);
    phase_start_d[2] = state_chg && (state_d == S_WRITE_BACK);
  end

  // Iteration count, latched limit and registered phase pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt_q    <= '0;
      limit_q       <= '0;
      phase_start_q <= '0;
    end else begin
      if (start_run) begin
        limit_q    <= iter_limit;
        iter_cnt_q <= '0;
      end else if (wb_adv) begin
        iter_cnt_q <= iter_inc;
      end
      phase_start_q <= phase_start_d;
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy        = run_busy;
    done        = (state_q == S_DONE);
    timeout_err = (state_q == S_ERR);
  end

  assign state       = state_q;
  assign phase_start = phase_start_q;
  assign iter_cnt    = iter_cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench: one DUT per parameter set, shared stimulus, table + hand sequences.
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_start = 1'b0, abort = 1'b0, is_find = 1'b0, is_finish = 1'b0;
  logic [15:0] iter_limit = '0;
  logic [2:0]  phase_done = '0;

  int checks = 0;
  int errors = 0;

  logic [2:0]  st_d, ps_d, st_l, ps_l, st_h, ps_h, st_t, ps_t;
  logic [15:0] it_d, it_l, it_h, it_t;
  logic        bz_d, dn_d, er_d, bz_l, dn_l, er_l, bz_h, dn_h, er_h, bz_t, dn_t, er_t;

  always #5 clk = ~clk;

  phase_sequencer u_def (
    .clk(clk), .rst_n(rst_n), .is_start(is_start), .abort(abort), .iter_limit(iter_limit),
    .is_find(is_find), .is_finish(is_finish), .phase_done(phase_done),
    .state(st_d), .phase_start(ps_d), .iter_cnt(it_d), .busy(bz_d), .done(dn_d), .timeout_err(er_d));

  phase_sequencer #(.DATA_LAT(3), .EX_LAT(2)) u_lat (
    .clk(clk), .rst_n(rst_n), .is_start(is_start), .abort(abort), .iter_limit(iter_limit),
    .is_find(is_find), .is_finish(is_finish), .phase_done(phase_done),
    .state(st_l), .phase_start(ps_l), .iter_cnt(it_l), .busy(bz_l), .done(dn_l), .timeout_err(er_l));

  phase_sequencer #(.HS_MODE(3'b010)) u_hs (
    .clk(clk), .rst_n(rst_n), .is_start(is_start), .abort(abort), .iter_limit(iter_limit),
    .is_find(is_find), .is_finish(is_finish), .phase_done(phase_done),
    .state(st_h), .phase_start(ps_h), .iter_cnt(it_h), .busy(bz_h), .done(dn_h), .timeout_err(er_h));

  phase_sequencer #(.TIMEOUT(4)) u_to (
    .clk(clk), .rst_n(rst_n), .is_start(is_start), .abort(abort), .iter_limit(iter_limit),
    .is_find(is_find), .is_finish(is_finish), .phase_done(phase_done),
    .state(st_t), .phase_start(ps_t), .iter_cnt(it_t), .busy(bz_t), .done(dn_t), .timeout_err(er_t));

  typedef struct {
    logic        start, abrt, find, fin;
    logic [15:0] lim;
    logic [2:0]  st;
    logic [15:0] it;
    logic [2:0]  ps;
    logic [2:0]  flg;   // {busy, done, timeout_err}
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic s, input logic a, input logic f, input logic n,
                              input logic [15:0] lim, input logic [2:0] st, input logic [15:0] it,
                              input logic [2:0] ps, input logic [2:0] flg);
    vec_t v;
    v.start = s; v.abrt = a; v.find = f; v.fin = n; v.lim = lim;
    v.st = st; v.it = it; v.ps = ps; v.flg = flg;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    is_start = 0; abort = 0; is_find = 0; is_finish = 0; phase_done = '0; iter_limit = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int st_exp[8];
    int ps_exp[8];
    int pulses;
    logic done_seen;

    // Test 1 table: limit=2 run, hold in DONE, restart with limit=1, abort, ignored finish/find.
    tbl[0]  = mk(1, 0, 1, 0, 16'd2, 3'd1, 16'd0, 3'b000, 3'b100);
    tbl[1]  = mk(0, 0, 1, 0, 16'd2, 3'd2, 16'd0, 3'b001, 3'b100);
    tbl[2]  = mk(0, 0, 1, 0, 16'd2, 3'd3, 16'd0, 3'b010, 3'b100);
    tbl[3]  = mk(0, 0, 1, 0, 16'd2, 3'd4, 16'd0, 3'b100, 3'b100);
    tbl[4]  = mk(0, 0, 1, 0, 16'd2, 3'd1, 16'd1, 3'b000, 3'b100);
    tbl[5]  = mk(0, 0, 1, 0, 16'd2, 3'd2, 16'd1, 3'b001, 3'b100);
    tbl[6]  = mk(0, 0, 1, 0, 16'd2, 3'd3, 16'd1, 3'b010, 3'b100);
    tbl[7]  = mk(0, 0, 1, 0, 16'd2, 3'd4, 16'd1, 3'b100, 3'b100);
    tbl[8]  = mk(0, 0, 1, 0, 16'd2, 3'd5, 16'd2, 3'b000, 3'b010);
    tbl[9]  = mk(0, 0, 1, 0, 16'd2, 3'd5, 16'd2, 3'b000, 3'b010);
    tbl[10] = mk(1, 0, 1, 0, 16'd1, 3'd1, 16'd0, 3'b000, 3'b100);
    tbl[11] = mk(0, 0, 1, 0, 16'd1, 3'd2, 16'd0, 3'b001, 3'b100);
    tbl[12] = mk(0, 0, 1, 0, 16'd1, 3'd3, 16'd0, 3'b010, 3'b100);
    tbl[13] = mk(0, 0, 1, 0, 16'd1, 3'd4, 16'd0, 3'b100, 3'b100);
    tbl[14] = mk(0, 0, 1, 0, 16'd1, 3'd5, 16'd1, 3'b000, 3'b010);
    tbl[15] = mk(0, 1, 1, 0, 16'd1, 3'd0, 16'd1, 3'b000, 3'b000);
    tbl[16] = mk(0, 0, 0, 1, 16'd1, 3'd0, 16'd1, 3'b000, 3'b000);
    tbl[17] = mk(0, 0, 1, 0, 16'd1, 3'd0, 16'd1, 3'b000, 3'b000);

    do_reset();
    chk("reset state", st_d, 0);
    chk("reset iter", it_d, 0);
    chk("reset pstart", ps_d, 0);
    chk("reset flags", {bz_d, dn_d, er_d}, 0);

    for (int i = 0; i < 18; i++) begin
      is_start = tbl[i].start; abort = tbl[i].abrt; is_find = tbl[i].find;
      is_finish = tbl[i].fin; iter_limit = tbl[i].lim;
      step();
      chk($sformatf("t1[%0d] state", i), st_d, tbl[i].st);
      chk($sformatf("t1[%0d] iter", i), it_d, tbl[i].it);
      chk($sformatf("t1[%0d] pstart", i), ps_d, tbl[i].ps);
      chk($sformatf("t1[%0d] flags", i), {bz_d, dn_d, er_d}, tbl[i].flg);
    end

    // Test 2: GET_DATA dwells 3 cycles, EX 2, one pulse per phase entry.
    do_reset();
    st_exp = '{1, 2, 2, 2, 3, 3, 4, 5};
    ps_exp = '{0, 1, 0, 0, 2, 0, 4, 0};
    pulses = 0;
    is_start = 1; is_find = 1; iter_limit = 16'd1;
    for (int i = 0; i < 8; i++) begin
      step();
      is_start = 0;
      chk($sformatf("t2[%0d] state", i), st_l, st_exp[i]);
      chk($sformatf("t2[%0d] pstart", i), ps_l, ps_exp[i]);
      pulses += int'(ps_l[0]) + int'(ps_l[1]) + int'(ps_l[2]);
    end
    chk("t2 pulse count", pulses, 3);
    chk("t2 done", dn_l, 1);

    // Test 3: EX waits on phase_done[1]; raised during GET_DATA it must not shorten EX.
    do_reset();
    is_start = 1; is_find = 1; iter_limit = 16'd1; phase_done = 3'b010;
    step(); is_start = 0;
    chk("t3 gp", st_h, 1);
    step();
    chk("t3 gd", st_h, 2);
    step();
    chk("t3 ex entry", st_h, 3);
    phase_done = 3'b000;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t3 ex hold %0d", k), st_h, 3);
    end
    phase_done = 3'b010;
    step();
    chk("t3 wb", st_h, 4);
    phase_done = 3'b000;
    step();
    chk("t3 done", st_h, 5);
    chk("t3 iter", it_h, 1);

    // Test 4: GET_PARAM timeout after 4 cycles; start ignored in ERR; abort recovers.
    do_reset();
    is_start = 1; is_find = 0; iter_limit = 16'd3;
    for (int k = 0; k < 4; k++) begin
      step(); is_start = 0;
      chk($sformatf("t4 gp %0d", k), st_t, 1);
    end
    step();
    chk("t4 err state", st_t, 6);
    chk("t4 err flags", {bz_t, dn_t, er_t}, 3'b001);
    is_start = 1;
    repeat (2) step();
    chk("t4 start ignored", st_t, 6);
    is_start = 0; abort = 1;
    step();
    chk("t4 abort state", st_t, 0);
    chk("t4 abort flags", {bz_t, dn_t, er_t}, 3'b000);
    abort = 0;

    // Test 5: abort beats is_finish; is_finish alone -> DONE; restart clears iter_cnt.
    do_reset();
    st_exp = '{1, 2, 3, 4, 1, 2, 3, 0};
    is_start = 1; is_find = 1; iter_limit = 16'd0;
    for (int i = 0; i < 7; i++) begin
      step(); is_start = 0;
      chk($sformatf("t5a[%0d] state", i), st_d, st_exp[i]);
    end
    chk("t5 iter before abort", it_d, 1);
    abort = 1; is_finish = 1;
    step();
    chk("t5 abort+finish state", st_d, 0);
    chk("t5 abort keeps iter", it_d, 1);
    abort = 0; is_finish = 0; is_start = 1;
    step(); is_start = 0;
    chk("t5 restart state", st_d, 1);
    chk("t5 restart iter", it_d, 0);
    st_exp = '{2, 3, 4, 1, 2, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t5b[%0d] state", i), st_d, st_exp[i]);
    end
    is_finish = 1;
    step();
    chk("t5 finish state", st_d, 5);
    chk("t5 finish done", dn_d, 1);
    chk("t5 finish iter", it_d, 1);
    is_finish = 0; is_start = 1;
    step(); is_start = 0;
    chk("t5 done restart state", st_d, 1);
    chk("t5 done restart iter", it_d, 0);

    // Test 6: unlimited run past 3 iterations, then async reset mid-WRITE_BACK.
    do_reset();
    done_seen = 1'b0;
    is_start = 1; is_find = 1; iter_limit = 16'd0;
    for (int i = 0; i < 20; i++) begin
      step(); is_start = 0;
      done_seen |= dn_d;
    end
    chk("t6 no done", done_seen, 0);
    chk("t6 state wb", st_d, 4);
    chk("t6 iter", it_d, 4);
    #2 rst_n = 0;
    #1;
    chk("t6 async state", st_d, 0);
    chk("t6 async iter", it_d, 0);
    chk("t6 async pstart", ps_d, 0);
    chk("t6 async flags", {bz_d, dn_d, er_d}, 0);
    @(negedge clk);
    rst_n = 1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
